// File: rtl/async_pkg.sv
// Shared types and helpers for the bundled-data micropipeline.
package async_pkg;

  typedef enum logic {
    PROTO_2PHASE = 1'b0,
    PROTO_4PHASE = 1'b1
  } protocol_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Convenience word type for users running the pipe at its default width.
  typedef logic [DEFAULT_WIDTH-1:0] word_t;

  // Any PHASES value other than 2 selects return-to-zero signalling.
  function automatic protocol_e proto_from_phases(input int unsigned phases);
    return (phases == 32'd2) ? PROTO_2PHASE : PROTO_4PHASE;
  endfunction

endpackage

// File: rtl/handshake_stage_m.sv
// One micropipeline stage: matched-delay line, registered C-element, data latch.
module handshake_stage_m
  import async_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DELAY = 2,
  parameter protocol_e   PROTO = PROTO_4PHASE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             ack_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             c_out,
  output logic [WIDTH-1:0] data_out,
  output logic             aclk_out
);

  logic d_c;
  logic c_next_c;
  logic capture_c;

  if (DELAY == 0) begin : g_no_delay
    assign d_c = req_in;
  end else begin : g_delay
    logic [DELAY-1:0] line_q;

    // Shift register modelling the matched delay; oldest sample at the MSB.
    always_ff @(posedge clk) begin
      if (reset) begin
        line_q <= '0;
      end else begin
        line_q <= DELAY'({line_q, req_in});
      end
    end

    assign d_c = line_q[DELAY-1];
  end

  // C-element: follow the delayed request only once the successor has caught up.
  assign c_next_c  = (d_c == ~ack_in) ? d_c : c_out;
  assign capture_c = (PROTO == PROTO_4PHASE) ? (c_next_c & ~c_out)
                                             : (c_next_c ^ c_out);

  // Controller state, latch and one-cycle latch-enable pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_out    <= 1'b0;
      data_out <= '0;
      aclk_out <= 1'b0;
    end else begin
      c_out    <= c_next_c;
      aclk_out <= capture_c;
      if (capture_c) begin
        data_out <= data_in;
      end
    end
  end

endmodule

// File: rtl/handshake_pipe_m.sv
// Bundled-data micropipeline: a chain of handshake stages between producer and consumer.
module handshake_pipe_m
  import async_pkg::*;
#(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DELAY  = 2,
  parameter int unsigned PHASES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              left_req_in,
  output logic              left_ack_out,
  input  logic [WIDTH-1:0]  left_data_in,
  output logic              right_req_out,
  input  logic              right_ack_in,
  output logic [WIDTH-1:0]  right_data_out,
  output logic [STAGES-1:0] aclk_out
);

  localparam protocol_e PROTO = proto_from_phases(PHASES);

  logic [STAGES-1:0] c;
  logic [WIDTH-1:0]  latch [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             req_c;
    logic             ack_c;
    logic [WIDTH-1:0] din_c;

    if (i == 0) begin : g_head
      assign req_c = left_req_in;
      assign din_c = left_data_in;
    end else begin : g_body
      assign req_c = c[i-1];
      assign din_c = latch[i-1];
    end

    if (i == STAGES - 1) begin : g_tail
      assign ack_c = right_ack_in;
    end else begin : g_inner
      assign ack_c = c[i+1];
    end

    handshake_stage_m #(
      .WIDTH (WIDTH),
      .DELAY (DELAY),
      .PROTO (PROTO)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .req_in   (req_c),
      .ack_in   (ack_c),
      .data_in  (din_c),
      .c_out    (c[i]),
      .data_out (latch[i]),
      .aclk_out (aclk_out[i])
    );
  end

  assign left_ack_out   = c[0];
  assign right_req_out  = c[STAGES-1];
  assign right_data_out = latch[STAGES-1];

  // Previous-cycle handshake levels, used only by the protocol checks below.
  logic left_req_q;
  logic right_ack_q;
  logic chk_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_valid_q <= 1'b0;
    end else begin
      chk_valid_q <= 1'b1;
    end
    left_req_q  <= left_req_in;
    right_ack_q <= right_ack_in;
  end

  // Environment may only move req once acked, and ack only while a req is pending.
  always_ff @(posedge clk) begin
    if (!reset && chk_valid_q) begin
      left_proto_chk: assert ((left_req_in == left_req_q) || (left_ack_out == left_req_q));
      right_proto_chk: assert ((right_ack_in == right_ack_q) || (right_req_out != right_ack_q));
    end
  end

endmodule

// File: tb/tb_handshake_pipe_m.sv
// Self-checking bench: three pipe configurations driven by handshaking producer/consumer tasks.
module tb_handshake_pipe_m;

  localparam int unsigned W    = 32;
  localparam int          NDUT = 3;
  localparam int          NRND = 1000;
  // dut0: 4-phase S4 D2, dut1: 2-phase S4 D2, dut2: 4-phase S2 D0
  localparam int STG  [NDUT] = '{4, 4, 2};
  localparam int DLY  [NDUT] = '{2, 2, 0};
  localparam bit FOUR [NDUT] = '{1'b1, 1'b0, 1'b1};

  logic         clk = 1'b0;
  logic         rst   [NDUT];
  logic         lreq  [NDUT];
  logic         lack  [NDUT];
  logic [W-1:0] ldata [NDUT];
  logic         rreq  [NDUT];
  logic         rack  [NDUT];
  logic [W-1:0] rdata [NDUT];
  logic [3:0]   aclk  [NDUT];
  logic [3:0]   aclk_a;
  logic [3:0]   aclk_b;
  logic [1:0]   aclk_cc;

  logic [W-1:0] words [NDUT][NRND];
  int           pulse_cnt [NDUT];
  int           n_vec = 0;
  int           n_bad = 0;

  typedef struct {
    int           k;
    logic [W-1:0] data;
    int           ack_lat;
    int           req_lat;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  handshake_pipe_m #(.STAGES(4), .WIDTH(W), .DELAY(2), .PHASES(4)) u_dut_a (
    .clk(clk), .reset(rst[0]), .left_req_in(lreq[0]), .left_ack_out(lack[0]),
    .left_data_in(ldata[0]), .right_req_out(rreq[0]), .right_ack_in(rack[0]),
    .right_data_out(rdata[0]), .aclk_out(aclk_a));

  handshake_pipe_m #(.STAGES(4), .WIDTH(W), .DELAY(2), .PHASES(2)) u_dut_b (
    .clk(clk), .reset(rst[1]), .left_req_in(lreq[1]), .left_ack_out(lack[1]),
    .left_data_in(ldata[1]), .right_req_out(rreq[1]), .right_ack_in(rack[1]),
    .right_data_out(rdata[1]), .aclk_out(aclk_b));

  handshake_pipe_m #(.STAGES(2), .WIDTH(W), .DELAY(0), .PHASES(4)) u_dut_c (
    .clk(clk), .reset(rst[2]), .left_req_in(lreq[2]), .left_ack_out(lack[2]),
    .left_data_in(ldata[2]), .right_req_out(rreq[2]), .right_ack_in(rack[2]),
    .right_data_out(rdata[2]), .aclk_out(aclk_cc));

  assign aclk[0] = aclk_a;
  assign aclk[1] = aclk_b;
  assign aclk[2] = {2'b00, aclk_cc};

  // Count last-stage latch pulses, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (aclk[k][STG[k]-1] === 1'b1) pulse_cnt[k]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_lack(input int k, input logic v, input int lim, output bit ok);
    int n = 0;
    while (lack[k] !== v && n < lim) begin
      step();
      n++;
    end
    ok = (lack[k] === v);
  endtask

  // One producer handshake; resume=1 continues a request already on the wire.
  task automatic produce(input int k, input logic [W-1:0] w, input bit resume,
                         input int lim, output bit ok);
    ok = 1'b1;
    if (!resume) begin
      ldata[k] = w;
      lreq[k]  = FOUR[k] ? 1'b1 : ~lreq[k];
    end
    if (FOUR[k]) begin
      wait_lack(k, 1'b1, lim, ok);
      if (ok) begin
        lreq[k] = 1'b0;
        wait_lack(k, 1'b0, lim, ok);
      end
    end else begin
      wait_lack(k, lreq[k], lim, ok);
    end
  endtask

  task automatic produce_stream(input int k, input int first, input int n, input int gap_pct,
                                input int lim, output int sent);
    bit ok;
    sent = 0;
    for (int i = first; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) step();
      produce(k, words[k][i], 1'b0, lim, ok);
      if (!ok) break;
      sent++;
    end
  endtask

  // Consumer: takes n words in order, checking each against the FIFO model.
  task automatic consume(input int k, input int n, input int ready_pct, input int lim,
                         output int got);
    int idle = 0;
    got = 0;
    while (got < n && idle < lim) begin
      step();
      idle++;
      if (int'($urandom_range(99)) < ready_pct) begin
        if (FOUR[k]) begin
          if (rreq[k] && !rack[k]) begin
            check($sformatf("dut%0d_word%0d", k, got), rdata[k], words[k][got]);
            rack[k] = 1'b1;
            got++;
            idle = 0;
          end else if (!rreq[k] && rack[k]) begin
            rack[k] = 1'b0;
          end
        end else if (rreq[k] !== rack[k]) begin
          check($sformatf("dut%0d_word%0d", k, got), rdata[k], words[k][got]);
          rack[k] = rreq[k];
          got++;
          idle = 0;
        end
      end
    end
  endtask

  // Let the pipe drain with an always-ready consumer that expects no new data.
  task automatic settle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rack[k] = rreq[k];
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int   k;
    int   got_ack;
    int   got_req;
    logic ack0;
    logic req0;
    logic [W-1:0] rd;
    k       = v.k;
    got_ack = -1;
    got_req = -1;
    ack0    = lack[k];
    req0    = rreq[k];
    rd      = '0;
    ldata[k] = v.data;
    lreq[k]  = ~lreq[k];
    for (int n = 1; n <= 60 && (got_ack < 0 || got_req < 0); n++) begin
      step();
      if (got_ack < 0 && lack[k] !== ack0) got_ack = n;
      if (got_req < 0 && rreq[k] !== req0) begin
        got_req = n;
        rd      = rdata[k];
        rack[k] = rreq[k];
      end
    end
    check($sformatf("vec dut%0d ack_latency", k), W'(got_ack), W'(v.ack_lat));
    check($sformatf("vec dut%0d req_latency", k), W'(got_req), W'(v.req_lat));
    check($sformatf("vec dut%0d data", k), rd, v.data);
    if (FOUR[k] && got_ack > 0) lreq[k] = 1'b0;
    settle(k, 40);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int got;
    int sent_a, sent_b, got_a, got_b;
    int base;
    int n;

    for (int k = 0; k < NDUT; k++) begin
      rst[k]   = 1'b1;
      lreq[k]  = 1'b0;
      rack[k]  = 1'b0;
      ldata[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("reset dut%0d left_ack", k), W'(lack[k]), '0);
      check($sformatf("reset dut%0d right_req", k), W'(rreq[k]), '0);
      check($sformatf("reset dut%0d right_data", k), rdata[k], '0);
      check($sformatf("reset dut%0d aclk", k), W'(aclk[k]), '0);
      rst[k] = 1'b0;
    end
    step();

    // Single-word latency vectors on an empty pipe.
    tbl[0] = '{0, 32'hDEADBEEF, DLY[0] + 1, STG[0] * (DLY[0] + 1)};
    tbl[1] = '{0, 32'h0BADF00D, DLY[0] + 1, STG[0] * (DLY[0] + 1)};
    tbl[2] = '{1, 32'h12345678, DLY[1] + 1, STG[1] * (DLY[1] + 1)};
    tbl[3] = '{1, 32'hCAFEF00D, DLY[1] + 1, STG[1] * (DLY[1] + 1)};
    tbl[4] = '{2, 32'h11111111, DLY[2] + 1, STG[2] * (DLY[2] + 1)};
    tbl[5] = '{2, 32'h22222222, DLY[2] + 1, STG[2] * (DLY[2] + 1)};
    for (int i = 0; i < 6; i++) apply_vec(tbl[i]);

    // 4-phase stall: consumer silent, five words offered.
    for (int i = 0; i < 5; i++) words[0][i] = W'(i + 1);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      produce(0, words[0][i], 1'b0, 60, ok);
      if (!ok) break;
      acc++;
    end
    check("stall4 accepted", W'(acc), W'(STG[0] / 2));
    fork
      begin
        int s;
        produce(0, words[0][acc], 1'b1, 200, ok);
        produce_stream(0, acc + 1, 5, 0, 200, s);
      end
      consume(0, 5, 100, 300, got);
    join
    check("stall4 delivered", W'(got), W'(5));
    settle(0, 40);

    // 2-phase stall: ack held, six transitions offered.
    for (int i = 0; i < 6; i++) words[1][i] = W'(32'hA0 + i);
    base = pulse_cnt[1];
    acc  = 0;
    for (int i = 0; i < 6; i++) begin
      produce(1, words[1][i], 1'b0, 60, ok);
      if (!ok) break;
      acc++;
    end
    check("stall2 accepted", W'(acc), W'(STG[1]));
    fork
      begin
        int s;
        produce(1, words[1][acc], 1'b1, 200, ok);
        produce_stream(1, acc + 1, 6, 0, 200, s);
      end
      consume(1, 6, 100, 300, got);
    join
    check("stall2 delivered", W'(got), W'(6));
    settle(1, 40);
    check("stall2 last_stage_pulses", W'(pulse_cnt[1] - base), W'(6));

    // Reset while two words are held and a third request is pending.
    produce(0, 32'h11, 1'b0, 60, ok);
    produce(0, 32'h22, 1'b0, 60, ok);
    ldata[0] = 32'h55;
    lreq[0]  = 1'b1;
    repeat (5) step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("midreset left_ack", W'(lack[0]), '0);
    check("midreset right_req", W'(rreq[0]), '0);
    check("midreset right_data", rdata[0], '0);
    check("midreset aclk", W'(aclk[0]), '0);
    base = pulse_cnt[0];
    n = 0;
    while (lack[0] !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check("midreset restart_latency", W'(n), W'(DLY[0] + 1));
    words[0][0] = 32'h55;
    fork
      begin
        lreq[0] = 1'b0;
        wait_lack(0, 1'b0, 60, ok);
      end
      consume(0, 1, 100, 100, got);
    join
    settle(0, 40);
    check("midreset delivered", W'(got), W'(1));
    check("midreset last_stage_pulses", W'(pulse_cnt[0] - base), W'(1));
    check("midreset idle right_req", W'(rreq[0]), '0);

    // Sustained transfer through the zero-delay pipe.
    for (int i = 0; i < 100; i++) words[2][i] = $urandom;
    fork
      produce_stream(2, 0, 100, 0, 100, sent_a);
      consume(2, 100, 100, 100, got_a);
    join
    check("sustained sent", W'(sent_a), W'(100));
    check("sustained received", W'(got_a), W'(100));
    settle(2, 10);

    // Random back-pressure on both protocols concurrently.
    for (int i = 0; i < NRND; i++) begin
      words[0][i] = $urandom;
      words[1][i] = $urandom;
    end
    fork
      produce_stream(0, 0, NRND, 20, 500, sent_a);
      consume(0, NRND, 70, 500, got_a);
      produce_stream(1, 0, NRND, 20, 500, sent_b);
      consume(1, NRND, 70, 500, got_b);
    join
    check("random4 sent", W'(sent_a), W'(NRND));
    check("random4 received", W'(got_a), W'(NRND));
    check("random2 sent", W'(sent_b), W'(NRND));
    check("random2 received", W'(got_b), W'(NRND));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
